// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: run-mode encoding and the default prescale ratio.
// The control FSM and the counter both import this package.
package stopwatch_pkg;

    localparam int TICK_DIV_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        MODE_DOWN = 2'b00,
        MODE_CLR  = 2'b01,
        MODE_UP   = 2'b10,
        MODE_STOP = 2'b11
    } mode_e;

    typedef struct packed {
        logic [2:0] min_tens;
        logic [3:0] min_ones;
        logic [2:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;
    localparam bcd_time_t TIME_ONE  = '{min_tens: 3'd0, min_ones: 4'd0, sec_tens: 3'd0, sec_ones: 4'd1};
    localparam bcd_time_t TIME_MAX  = '{min_tens: 3'd5, min_ones: 4'd9, sec_tens: 3'd5, sec_ones: 4'd9};

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle between the stopwatch control FSM (master) and the
// counter (slave): run mode and add-5 level in, BCD time and event pulses out.
interface stopwatch_counter_if;

    logic [1:0] mode;
    logic       l;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic       tick;
    logic       done;
    logic       wrap;

    modport master (
        output mode, l,
        input  sec_ones, sec_tens, min_ones, min_tens, tick, done, wrap
    );

    modport slave (
        input  mode, l,
        output sec_ones, sec_tens, min_ones, min_tens, tick, done, wrap
    );

endinterface

// File: rtl/stopwatch_counter_tick_gen.sv
// Prescaler 0..TICK_DIV-1 with enable and synchronous clear; tick is combinational
// on the terminal count while enabled. No backpressure: free-running when enabled.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic r,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en & (cnt == LAST);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch: up/down count on prescaled ticks, clear, and edge-triggered add-5.
// Time is registered (1 cycle); tick/done/wrap are same-cycle pulses. No backpressure.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                r,
    stopwatch_counter_if.slave  sw
);

    bcd_time_t cur;
    bcd_time_t nxt;
    logic      l_d;
    logic      is_up;
    logic      is_down;
    logic      is_clr;
    logic      at_zero;
    logic      pre_en;
    logic      pre_clr;
    logic      tick;

    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.sec_ones != 4'd9) begin
            n.sec_ones = t.sec_ones + 4'd1;
        end else begin
            n.sec_ones = 4'd0;
            if (t.sec_tens != 3'd5) begin
                n.sec_tens = t.sec_tens + 3'd1;
            end else begin
                n.sec_tens = 3'd0;
                if (t.min_ones != 4'd9) begin
                    n.min_ones = t.min_ones + 4'd1;
                end else begin
                    n.min_ones = 4'd0;
                    n.min_tens = (t.min_tens == 3'd5) ? 3'd0 : t.min_tens + 3'd1;
                end
            end
        end
        return n;
    endfunction

    // Only reached with a non-zero time, so the borrow chain never underflows.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.sec_ones != 4'd0) begin
            n.sec_ones = t.sec_ones - 4'd1;
        end else begin
            n.sec_ones = 4'd9;
            if (t.sec_tens != 3'd0) begin
                n.sec_tens = t.sec_tens - 3'd1;
            end else begin
                n.sec_tens = 3'd5;
                if (t.min_ones != 4'd0) begin
                    n.min_ones = t.min_ones - 4'd1;
                end else begin
                    n.min_ones = 4'd9;
                    n.min_tens = t.min_tens - 3'd1;
                end
            end
        end
        return n;
    endfunction

    // Carry case: force units to 9 and reuse the increment chain for the carry.
    function automatic bcd_time_t bcd_add5(input bcd_time_t t);
        bcd_time_t n;
        bcd_time_t c;
        if (t.min_tens == 3'd5 && t.min_ones == 4'd9 && t.sec_tens == 3'd5 && t.sec_ones >= 4'd5) begin
            n = TIME_MAX;
        end else if (t.sec_ones < 4'd5) begin
            n = t;
            n.sec_ones = t.sec_ones + 4'd5;
        end else begin
            c = t;
            c.sec_ones = 4'd9;
            n = bcd_inc(c);
            n.sec_ones = t.sec_ones - 4'd5;
        end
        return n;
    endfunction

    assign is_up   = (sw.mode == MODE_UP);
    assign is_down = (sw.mode == MODE_DOWN);
    assign is_clr  = (sw.mode == MODE_CLR);
    assign at_zero = (cur == TIME_ZERO);

    // A down count parked at 00:00 keeps the prescaler cleared so nothing fires.
    assign pre_en  = is_up | (is_down & ~at_zero);
    assign pre_clr = is_clr | (is_down & at_zero);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .r    (r),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_comb begin
        nxt = cur;
        if (is_clr) begin
            if (!sw.l) begin
                nxt = TIME_ZERO;
            end else if (!l_d) begin
                nxt = bcd_add5(cur);
            end
        end else if (tick) begin
            nxt = is_up ? bcd_inc(cur) : bcd_dec(cur);
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            cur <= TIME_ZERO;
            l_d <= 1'b0;
        end else begin
            cur <= nxt;
            l_d <= sw.l;
        end
    end

    assign sw.sec_ones = cur.sec_ones;
    assign sw.sec_tens = cur.sec_tens;
    assign sw.min_ones = cur.min_ones;
    assign sw.min_tens = cur.min_tens;
    assign sw.tick     = tick;
    assign sw.done     = tick & is_down & (cur == TIME_ONE);
    assign sw.wrap     = tick & is_up & (cur == TIME_MAX);

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clock cycles per counted second (minimum 2).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 r  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 mode  input  2  run mode from the stopwatch control FSM: 2'b10 up, 2'b00 down, 2'b11 stop, 2'b01 clear/add5.
REQ-005 l  input  1  add-5-seconds request level, the same signal the control FSM samples; synchronous to clk.
REQ-006 sec_ones  output  4  BCD seconds units, 0-9.
REQ-007 sec_tens  output  3  BCD seconds tens, 0-5.
REQ-008 min_ones  output  4  BCD minutes units, 0-9.
REQ-009 min_tens  output  3  BCD minutes tens, 0-5.
REQ-010 tick  output  1  one-cycle pulse marking a counted second in up/down mode.
REQ-011 done  output  1  one-cycle pulse when a down count reaches 00:00.
REQ-012 wrap  output  1  one-cycle pulse when an up count rolls 59:59 -> 00:00.

Function
REQ-013 Prescaler counts 0..TICK_DIV-1 only in up/down mode; tick is high combinationally while the prescaler is at TICK_DIV-1 in up/down mode, and the prescaler then returns to 0.
REQ-014 In stop mode the prescaler and time value hold, and tick/done/wrap are 0.
REQ-015 In clear/add5 mode the prescaler is cleared to 0 every cycle.
REQ-016 Up mode: on the tick edge the time increments by one second with BCD carry (sec_ones 9->0 carries to sec_tens, sec_tens 5->0 carries to min_ones, min_ones 9->0 carries to min_tens).
REQ-017 Up mode at 59:59 on tick: the next value is 00:00 and wrap is high for that same cycle.
REQ-018 Down mode: on the tick edge the time decrements by one second with BCD borrow.
REQ-019 Down mode at 00:01 on tick: the next value is 00:00 and done is high for that same cycle.
REQ-020 Down mode at 00:00: the time holds, no tick, no done, and the prescaler stays cleared (saturate, no underflow).
REQ-021 Clear/add5 mode with l=0: the time is cleared to 00:00 on the next edge.
REQ-022 Clear/add5 mode on a rising edge of l (registered l_d=0, l=1): add exactly 5 seconds once, with BCD carry into minutes.
REQ-023 The add5 saturates at 59:59 if the sum exceeds it; wrap is not asserted.
REQ-024 Clear/add5 mode with l held high after its rising edge: the time holds; further increments require l to fall and rise again.
REQ-025 l_d is updated every cycle regardless of mode; an l rise seen in any other mode does not add.
REQ-026 All time outputs are registered: a change appears one cycle after the qualifying edge. done/wrap/tick have zero added latency relative to the counting edge.
REQ-027 A mode change takes effect on the first edge at which the new mode is sampled; a pending prescaler count is kept across up<->down changes.

Reset
REQ-028 While r=0: all digits 0, prescaler 0, l_d 0; tick, done and wrap are 0.
REQ-029 Reset assertion mid-count aborts immediately (asynchronously); after release, counting resumes from 00:00 with a full TICK_DIV period before the first tick.

Structure
REQ-030 Package stopwatch_pkg holds the mode constants MODE_UP=2'b10, MODE_DOWN=2'b00, MODE_STOP=2'b11, MODE_CLR=2'b01 and the TICK_DIV default; the control FSM and this block share these constants.
REQ-031 Sub-module tick_gen (prescaler with enable and sync clear, outputs tick) is instantiated once; the BCD time register and add5/inc/dec logic stay in stopwatch_counter.

Verification (TICK_DIV=4)
REQ-032 Reset release, mode=10 for 12 cycles -> ticks on cycles 4, 8, 12; time 00:03.
REQ-033 Preload 59:59 via add5 steps, mode=10 for one tick -> 00:00 with wrap high for 1 cycle.
REQ-034 Time 00:02, mode=00 for 12 cycles -> 00:01, then 00:00 with done pulse on the second tick; no further ticks; value holds at 00:00.
REQ-035 Time 00:58, mode=01, l pulsed 0->1 and held 3 cycles -> 01:03 exactly once; l low -> 00:00 on the next edge.
REQ-036 Time 59:57, mode=01, l rises -> 59:59 saturated, wrap=0.
REQ-037 Mode=10 running at 00:07, r driven low between edges -> outputs 0 immediately; after release with mode=10, the first tick comes 4 cycles later.
